reg_response_serializer: RTL

- Reply path of the register-access command interface.
- Takes read/write strobes from the command decoder and read data from the register file.
- Builds a response frame and serialises it one word at a time over a valid/ready stream to the UART transmitter.
- Response frame format: CA[V...], where C is the status/command word, A is the address, and V is the value (read replies only), most-significant word first.

---
 rtl/reg_response_serializer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/reg_response_serializer.sv
// rtl/reg_response_serializer.sv - register-access reply framer and word serializer
module reg_response_serializer #(
  parameter int WORD_WIDTH   = 8,
  parameter int VALUE_WORDS  = 4,
  parameter int READ_TIMEOUT = 16
) (
  input  logic                              clk,
  input  logic                              i_reset_n,
  input  logic                              i_r_en,
  input  logic [WORD_WIDTH-1:0]             i_r_addr,
  input  logic                              i_w_en,
  input  logic [WORD_WIDTH-1:0]             i_w_addr,
  input  logic [VALUE_WORDS*WORD_WIDTH-1:0] i_r_data,
  input  logic                              i_r_dv,
  output logic [WORD_WIDTH-1:0]             o_tx_data,
  output logic                              o_tx_valid,
  input  logic                              i_tx_ready,
  output logic                              o_busy,
  output logic                              o_overrun
);

  localparam int FRAME_WORDS = VALUE_WORDS + 2;
  localparam int FRAME_W     = FRAME_WORDS * WORD_WIDTH;
  localparam int VAL_W       = VALUE_WORDS * WORD_WIDTH;
  localparam int CW          = $clog2(FRAME_WORDS + 1);
  localparam int TW          = $clog2(READ_TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  localparam logic [WORD_WIDTH-1:0] ST_READ_OK   = WORD_WIDTH'(8'h00);
  localparam logic [WORD_WIDTH-1:0] ST_WRITE_ACK = WORD_WIDTH'(8'haa);
  localparam logic [WORD_WIDTH-1:0] ST_TIMEOUT   = WORD_WIDTH'(8'hee);

  logic [1:0]            r_state;
  logic [FRAME_W-1:0]    r_frame;
  logic [WORD_WIDTH-1:0] r_addr;
  logic [CW-1:0]         r_len;
  logic [CW-1:0]         r_wcnt;
  logic [TW-1:0]         r_tcnt;
  logic                  r_tx_valid;
  logic                  r_busy;
  logic                  r_overrun;

  logic w_xfer;
  logic w_last;
  logic w_drop;

  assign w_xfer = r_tx_valid & i_tx_ready;
  assign w_last = (r_wcnt == (r_len - CW'(1)));
  // In IDLE only a simultaneous read+write loses a request; elsewhere any new request is lost.
  assign w_drop = (r_state == S_IDLE) ? (i_r_en & i_w_en) : (i_r_en | i_w_en);

  assign o_tx_data  = r_frame[FRAME_W-1 -: WORD_WIDTH];
  assign o_tx_valid = r_tx_valid;
  assign o_busy     = r_busy;
  assign o_overrun  = r_overrun;

  // Main FSM: capture request, wait for read data or timeout, then shift the frame out MSW first.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_frame    <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_wcnt     <= '0;
      r_tcnt     <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_r_en) begin
            r_addr  <= i_r_addr;
            r_tcnt  <= '0;
            r_state <= S_WAIT;
            r_busy  <= 1'b1;
          end else if (i_w_en) begin
            r_frame    <= {ST_WRITE_ACK, i_w_addr, {VAL_W{1'b0}}};
            r_len      <= CW'(2);
            r_wcnt     <= '0;
            r_tx_valid <= 1'b1;
            r_state    <= S_SEND;
            r_busy     <= 1'b1;
          end
        end
        S_WAIT: begin
          if (i_r_dv) begin
            r_frame    <= {ST_READ_OK, r_addr, i_r_data};
            r_len      <= CW'(FRAME_WORDS);
            r_wcnt     <= '0;
            r_tx_valid <= 1'b1;
            r_state    <= S_SEND;
          end else if (r_tcnt == TW'(READ_TIMEOUT - 1)) begin
            r_frame    <= {ST_TIMEOUT, r_addr, {VAL_W{1'b0}}};
            r_len      <= CW'(2);
            r_wcnt     <= '0;
            r_tx_valid <= 1'b1;
            r_state    <= S_SEND;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        S_SEND: begin
          if (w_xfer) begin
            r_frame <= {r_frame[FRAME_W-WORD_WIDTH-1:0], {WORD_WIDTH{1'b0}}};
            r_wcnt  <= r_wcnt + CW'(1);
            if (w_last) begin
              r_tx_valid <= 1'b0;
              r_state    <= S_IDLE;
              r_busy     <= 1'b0;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  // One-cycle pulse for every cycle in which a request had to be discarded.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_drop;
    end
  end

endmodule
